// File: rtl/tdm_demux.sv
// tdm_demux: sequential 1-to-NCH time-division demultiplexer.
// An interleaved sample stream (one sample per valid cycle, channel 0 marked
// by sync) is steered into NCH per-channel holding registers by a rotating
// channel counter. Per-channel update pulses, a frame-done pulse and a
// sync-misalignment pulse are all registered, so there is no combinational
// path from inputs to outputs.
module tdm_demux #(
  parameter int WIDTH = 1,   // data bits per sample
  parameter int NCH   = 4,   // channel count, power of 2, >= 2
  parameter int SELW  = 2    // counter width, must equal log2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  sync,
  input  logic [WIDTH-1:0]      x,
  output logic [NCH*WIDTH-1:0]  y,
  output logic [NCH-1:0]        out_valid,
  output logic [SELW-1:0]       sel,
  output logic                  frame_done,
  output logic                  sync_err
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  logic [NCH*WIDTH-1:0] y_q, y_d;
  logic [NCH-1:0]       out_valid_q, out_valid_d;
  logic [SELW-1:0]      sel_q, sel_d;
  logic                 frame_done_q, frame_done_d;
  logic                 sync_err_q, sync_err_d;
  logic [SELW-1:0]      tgt;

  // Next-state: pick the target channel, decode it into a write enable, update counter and pulses.
  always_comb begin
    // NOTE: every signal gets a default before any branch; otherwise a path
    // that skips an assignment would infer a latch.
    y_d          = y_q;
    out_valid_d  = '0;
    sel_d        = sel_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    // A sync sample always realigns to channel 0, wherever the counter was.
    tgt          = sync ? '0 : sel_q;

    if (in_valid) begin
      // Counter is exactly log2(NCH) bits, so the increment wraps NCH-1 -> 0.
      sel_d        = tgt + SELW'(1);
      frame_done_d = (tgt == LAST_CH);
      sync_err_d   = sync && (sel_q != '0);
      for (int k = 0; k < NCH; k++) begin
        if (tgt == SELW'(k)) begin
          out_valid_d[k]            = 1'b1;
          y_d[k*WIDTH +: WIDTH]     = x;
        end
      end
    end
  end

  // State registers with synchronous reset; reset wins over a same-cycle sample.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (rst) begin
      // NOTE: the holding registers are reset too, because y must read 0
      // after reset rather than stale channel data.
      y_q          <= '0;
      out_valid_q  <= '0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      y_q          <= y_d;
      out_valid_q  <= out_valid_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign y          = y_q;
  assign out_valid  = out_valid_q;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (NCH=4, WIDTH=1). A behavioural model
// pushes the expected output word for every driven cycle onto a queue; each
// scenario task pops it after the clock edge and compares, and also checks
// the hand-derived values from the test plan against constants.
module tb_tdm_demux;

  localparam int WIDTH = 1;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 sync;
  logic [WIDTH-1:0]     x;
  logic [NCH*WIDTH-1:0] y;
  logic [NCH-1:0]       out_valid;
  logic [SELW-1:0]      sel;
  logic                 frame_done;
  logic                 sync_err;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] ov;
    logic [1:0] sel;
    logic       fd;
    logic       se;
  } obs_t;

  obs_t obs;
  obs_t exp_o;
  obs_t sb[$];

  int checks = 0;
  int errors = 0;

  // model state
  logic [3:0] m_y;
  logic [1:0] m_sel;

  assign obs = {y, out_valid, sel, frame_done, sync_err};

  tdm_demux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .sync       (sync),
    .x          (x),
    .y          (y),
    .out_valid  (out_valid),
    .sel        (sel),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of stimulus, push the model's expectation, and return
  // 1 time unit after the capturing edge.
  task automatic cycle(input logic r, input logic v, input logic s, input logic xi);
    obs_t e;
    int   t;
    rst = r; in_valid = v; sync = s; x = xi;
    e = '0;
    if (r) begin
      m_y   = 4'b0000;
      m_sel = 2'd0;
    end else if (v) begin
      t = s ? 0 : int'(m_sel);
      e.se = s && (m_sel != 2'd0);
      m_y[t] = xi;
      e.ov = 4'(1 << t);
      e.fd = (t == NCH - 1);
      m_sel = 2'((t + 1) % NCH);
    end
    e.y   = m_y;
    e.sel = m_sel;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(i < 2, i < 2, 1'b0, 1'b1);
      exp_o = sb.pop_front();
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL reset_sb[%0d]: got %h want %h", i, obs, exp_o);
      end
      checks++;
      if ({y, out_valid, sel, frame_done, sync_err} !== 12'h000) begin
        errors++;
        $display("FAIL reset_zero[%0d]: got %h want 000", i, obs);
      end
    end
  endtask

  task automatic test_full_frame();
    logic [3:0] xs;
    int fd_cnt;
    xs = 4'b1101;  // bit i is the sample for channel i: 1,0,1,1
    fd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, i == 0, xs[i]);
      exp_o = sb.pop_front();
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL frame_sb[%0d]: got %h want %h", i, obs, exp_o);
      end
      checks++;
      if (out_valid !== 4'(1 << i)) begin
        errors++;
        $display("FAIL frame_ov[%0d]: got %b want %b", i, out_valid, 4'(1 << i));
      end
      if (frame_done === 1'b1) fd_cnt++;
    end
    checks++;
    if (y !== 4'b1101 || frame_done !== 1'b1 || sel !== 2'd0 || fd_cnt != 1) begin
      errors++;
      $display("FAIL frame_end: got y=%b fd=%b sel=%0d fd_cnt=%0d want y=1101 fd=1 sel=0 fd_cnt=1",
               y, frame_done, sel, fd_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] xs;
    xs = 4'b0100;  // samples 0,0,1,0
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, xs[i]);
      exp_o = sb.pop_front();
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL wrap_sb[%0d]: got %h want %h", i, obs, exp_o);
      end
      if (i == 0) begin
        checks++;
        if (out_valid !== 4'b0001) begin
          errors++;
          $display("FAIL wrap_first: got %b want 0001", out_valid);
        end
      end
    end
    checks++;
    if (y !== 4'b0100 || frame_done !== 1'b1 || sel !== 2'd0) begin
      errors++;
      $display("FAIL wrap_end: got y=%b fd=%b sel=%0d want y=0100 fd=1 sel=0", y, frame_done, sel);
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 5; i++) begin
      // sync is held high during the idles to show it is ignored without in_valid
      cycle(1'b0, (i == 0) || (i == 4), (i != 0) && (i != 4), 1'b1);
      exp_o = sb.pop_front();
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL gaps_sb[%0d]: got %h want %h", i, obs, exp_o);
      end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (sel !== 2'd1 || y !== 4'b0101 || out_valid !== 4'b0000 || sync_err !== 1'b0) begin
          errors++;
          $display("FAIL gaps_idle[%0d]: got sel=%0d y=%b ov=%b se=%b want sel=1 y=0101 ov=0000 se=0",
                   i, sel, y, out_valid, sync_err);
        end
      end
    end
    checks++;
    if (y !== 4'b0111 || out_valid !== 4'b0010 || sel !== 2'd2) begin
      errors++;
      $display("FAIL gaps_end: got y=%b ov=%b sel=%0d want y=0111 ov=0010 sel=2", y, out_valid, sel);
    end
  endtask

  task automatic test_misaligned_sync();
    logic [3:0] xs;
    xs = 4'b0110;  // ch2=0, ch3=1, ch0=1, ch1=0 (finish frame, then 2 samples)
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, xs[i]);
      exp_o = sb.pop_front();
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL missync_pre[%0d]: got %h want %h", i, obs, exp_o);
      end
    end
    checks++;
    if (sel !== 2'd2 || y !== 4'b1001) begin
      errors++;
      $display("FAIL missync_setup: got sel=%0d y=%b want sel=2 y=1001", sel, y);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    exp_o = sb.pop_front();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL missync_sb: got %h want %h", obs, exp_o);
    end
    checks++;
    if (sync_err !== 1'b1 || out_valid !== 4'b0001 || y !== 4'b1000 || sel !== 2'd1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL missync: got se=%b ov=%b y=%b sel=%0d fd=%b want se=1 ov=0001 y=1000 sel=1 fd=0",
               sync_err, out_valid, y, sel, frame_done);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    exp_o = sb.pop_front();
    checks++;
    if (obs !== exp_o || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL missync_pulse: got %h want %h", obs, exp_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    cycle(1'b0, 1'b1, 1'b0, 1'b1);  // ch1
    cycle(1'b0, 1'b1, 1'b0, 1'b1);  // ch2 -> sel=3
    for (int i = 0; i < 2; i++) begin
      exp_o = sb.pop_front();
      checks++;
      if (obs !== exp_o && i == 1) begin
        errors++;
        $display("FAIL midrst_pre: got %h want %h", obs, exp_o);
      end
    end
    checks++;
    if (sel !== 2'd3) begin
      errors++;
      $display("FAIL midrst_setup: got sel=%0d want 3", sel);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b1);  // reset drops this sample
    exp_o = sb.pop_front();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL midrst_rst: got %h want %h", obs, exp_o);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    exp_o = sb.pop_front();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL midrst_sb: got %h want %h", obs, exp_o);
    end
    checks++;
    if (y !== 4'b0001 || out_valid !== 4'b0001 || sel !== 2'd1) begin
      errors++;
      $display("FAIL midrst: got y=%b ov=%b sel=%0d want y=0001 ov=0001 sel=1", y, out_valid, sel);
    end
  endtask

  task automatic test_back_to_back();
    int ov_bits;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
      exp_o = sb.pop_front();
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL b2b_sb[%0d]: got %h want %h", i, obs, exp_o);
      end
      ov_bits = $countones(out_valid);
      checks++;
      if (ov_bits > 1) begin
        errors++;
        $display("FAIL b2b_onehot[%0d]: got %b want at most one bit", i, out_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; sync = 1'b0; x = '0;
    m_y = 4'b0000; m_sel = 2'd0;
    test_reset();
    test_full_frame();
    test_wrap();
    test_gaps();
    test_misaligned_sync();
    test_reset_mid_frame();
    test_back_to_back();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_left: got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Sequential 1-to-NCH time-division demultiplexer; the receive-side counterpart of the team's 2:1 / N:1 select multiplexers.
- Accepts one interleaved sample stream, one sample per valid cycle, with channel 0 marked by a sync flag.
- Steers each sample into a per-channel holding register using an internal rotating channel counter.
- Signals per-channel updates, frame completion and sync misalignment.

Parameters:
- WIDTH, 1, data bits per sample.
- NCH, 4, number of output channels; must be ≥ 2 and a power of 2.
- SELW, 2, channel counter width; must equal log2(NCH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  x carries a sample this cycle.
- sync  input  1  qualified by in_valid; this sample belongs to channel 0.
- x  input  WIDTH  interleaved sample input.
- y  output  NCH*WIDTH  held channel samples; channel k is y[k*WIDTH +: WIDTH].
- out_valid  output  NCH  one-cycle pulse; bit k is set in the cycle after channel k is written.
- sel  output  SELW  channel the next non-sync sample will be written to.
- frame_done  output  1  one-cycle pulse after channel NCH-1 is written.
- sync_err  output  1  one-cycle pulse after a sync arrives while sel ≠ 0.

Behaviour:
- All state changes on the rising edge of clk; no combinational path from inputs to outputs.
- Reset (rst=1 at a clock edge):
  - y=0, out_valid=0, sel=0, frame_done=0, sync_err=0.
  - Reset overrides in_valid in the same cycle; the sample is dropped.
  - Reset mid-frame discards the partial frame; the next sample goes to channel 0.
- Channel selection (in_valid=1):
  - Target channel t = 0 if sync=1, else t = sel.
  - Next cycle: y[t] = x; out_valid = one-hot bit t; sel = (t+1) mod NCH.
  - Counter wraps NCH-1 → 0 with no sync required (free-running frames).
- sync_err:
  - Next cycle = 1 if in_valid=1, sync=1 and sel ≠ 0.
  - The realignment still happens: the sample goes to channel 0 and sel becomes 1.
  - The channels skipped in the broken frame keep their old values.
- frame_done:
  - Next cycle = 1 if t = NCH-1 was written.
  - When NCH-1 is reached through resync, it still pulses only on an actual channel NCH-1 write.
- Idle (in_valid=0):
  - sel and y hold.
  - out_valid, frame_done and sync_err are 0 next cycle.
  - sync is ignored while in_valid=0.
- Latency: exactly 1 cycle from sample to y/out_valid. Back-to-back samples are accepted every cycle; there is no back-pressure.
- Channels not written in a cycle hold their y value.
- At most one out_valid bit is set per cycle.
- Implementation: SELW-bit counter, write-enable decoder and NCH holding registers. The decoder is a loop or generate; there is no per-channel copy-paste.

Test Plan:
- Reset: NCH=4, WIDTH=1. Apply rst for 2 cycles with in_valid=1, x=1. Expect y=0, out_valid=0, sel=0, frame_done=0 throughout and one cycle after.
- Full frame: feed x=1,0,1,1 on 4 consecutive cycles, sync only on the first. Expect:
  - out_valid = 0001, 0010, 0100, 1000 on successive cycles.
  - y = 4'b1101 after the 4th sample.
  - frame_done pulses once, with the 4th out_valid.
  - sel ends at 0.
- Wrap without sync: continue with 4 more samples 0,0,1,0 and no sync. Expect channel 0 written first (wrap), y=4'b0100, frame_done pulses again.
- Gaps: samples 1,1 with in_valid=0 idles of 3 cycles between them. Expect sel and y to hold during the gaps and out_valid=0 in idle cycles.
- Misaligned sync: after 2 samples (sel=2), send sync with x=0. Expect:
  - sync_err=1 for one cycle.
  - out_valid=0001, y[0]=0, sel=1.
  - y[2] and y[3] unchanged.
  - No frame_done.
- Reset mid-frame: at sel=3, assert rst for one cycle, then send one sample x=1 with no sync. Expect y=4'b0001, out_valid=0001, sel=1.
